keypad_timer: RTL and testbench
===============================

// Module: keypad_timer
// PURPOSE
//  Receiving end of the keypad encoder interface in the microwave datapath.
//  Consumes the encoder's BCD digit (D), key-held flag (loadn) and strobe (pgt_1Hz).
//  In entry mode, each strobe shifts the pressed digit into a 4-digit MM:SS register.
//  In count mode, each strobe is a 1 Hz tick that decrements MM:SS in BCD down to 00:00.
//  Drives the display digits and the zero/done flags used by the oven controller.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth for pgt_1Hz, D and loadn (minimum 2)
// PORTS
//  clk        in   1  system clock; the only clock
//  clearn     in   1  asynchronous active-low reset
//  D          in   4  BCD digit from the encoder; valid while loadn=0
//  loadn      in   1  0 = a key is held (D valid)
//  pgt_1Hz    in   1  key strobe (entry mode) or 1 Hz tick (count mode); async to clk
//  enablen    in   1  0 = entry mode, 1 = count mode; synchronous to clk
//  clr_time   in   1  synchronous clear of all digits (cancel key)
//  sec_ones   out  4  BCD seconds units
//  sec_tens   out  4  BCD seconds tens
//  min_ones   out  4  BCD minutes units
//  min_tens   out  4  BCD minutes tens
//  zero       out  1  1 when all four digits are 0 (combinational from the digit registers)
//  done       out  1  one-clk pulse when a count-mode decrement reaches 00:00
// BEHAVIOUR
//  Reset (clearn=0, async): all digits 0; zero=1; done=0. All synchroniser and
//   edge flops reset to 1, so a pgt_1Hz held high across reset release gives no tick.
//  Tick: pgt_1Hz passes through SYNC_STAGES flops plus one edge flop; tick = sync&~prev.
//   Digits update on the 3rd rising clk edge after pgt_1Hz rises (SYNC_STAGES=2).
//   D and loadn pass through an equal-depth synchroniser, so they are aligned with tick.
//  Priority per clk edge: clr_time > tick. clr_time sets all digits to 0 and never pulses done.
//  Entry mode (enablen=0), on tick with synced loadn=0 and synced D<=9:
//   min_tens<=min_ones; min_ones<=sec_tens; sec_tens<=sec_ones; sec_ones<=D.
//   The oldest digit is discarded. D in 10..15, or loadn=1, ignores the tick.
//   sec_tens may hold up to 9 (e.g. "99" entered = 00:99 is legal).
//  Count mode (enablen=1), on tick:
//   - If zero=1: no change and no done.
//   - Otherwise BCD-decrement the time with borrow chain:
//     sec_ones: 0->9 with borrow. sec_tens: 0->5 with borrow, else -1.
//     min_ones: 0->9 with borrow. min_tens: -1.
//   - If the result is 00:00: done=1 for exactly one clk.
//  Mode change (enablen toggling) takes effect on the next tick; the digits are not altered.
//  Reset mid-count: immediately 00:00; a pending synchronised tick is discarded.
//  done and digit outputs are registered; zero is the only combinational output.
// STRUCTURE
//  Package microwave_pkg: BCD_W=4, BCD_MAX=4'd9, SEC_TENS_MAX=4'd5, and the
//   MODE_ENTRY/MODE_COUNT constants for enablen.
//  Sub-module bcd_digit: one 4-bit digit register with load, shift-in, and decrement.
//   Decrement takes borrow_in and a wrap-value input, and produces borrow_out.
//   bcd_digit is instantiated 4x; the synchroniser and edge detect live in the top.
// TESTING
//  1 Hold pgt_1Hz=1 through reset, then release -> 00:00, zero=1, done=0, no shift occurs.
//  2 Entry: keys 1,3,0, each with a pgt pulse -> 01:30; 3rd clk edge latency checked on every update.
//  3 Entry: D=4'hC with a pulse, then loadn=1 with a pulse -> digits unchanged.
//  4 Entry: keys 1..5 -> 23:45 (the 1 is dropped). Entry: 9,9, then count mode with 1 tick -> 00:98.
//  5 Count from 01:00: 1 tick -> 00:59; 59 more ticks -> 00:00 with done for one clk.
//    A 61st tick -> no change, done stays 0.
//  6 clr_time coincident with a tick at 12:34 -> 00:00, done=0. Async reset mid-count at 00:07 -> 00:00.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave keypad/timer datapath.
// Digits are 4-bit BCD; enablen selects entry or count mode.
package microwave_pkg;

    localparam int         BCD_W        = 4;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic       MODE_ENTRY   = 1'b0;
    localparam logic       MODE_COUNT   = 1'b1;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: synchronous clear, shift-in load, and
// decrement-with-borrow that wraps to a per-digit value.
module bcd_digit
    import microwave_pkg::*;
(
    input  logic             clk,
    input  logic             clearn,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [BCD_W-1:0] shift_in,
    input  logic             dec_en,
    input  logic             borrow_in,
    input  logic [BCD_W-1:0] wrap_val,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_r;
    logic [BCD_W-1:0] digit_next_s;

    // A digit only moves when every lower digit is wrapping (borrow_in).
    assign borrow_out = borrow_in && (digit_r == 4'd0);
    assign digit      = digit_r;

    // Next-value selection: clear beats shift beats decrement.
    always_comb begin
        digit_next_s = digit_r;
        if (clr) begin
            digit_next_s = 4'd0;
        end else if (shift_en) begin
            digit_next_s = shift_in;
        end else if (dec_en && borrow_in) begin
            if (digit_r == 4'd0) begin
                digit_next_s = wrap_val;
            end else begin
                digit_next_s = digit_r - 4'd1;
            end
        end else begin
            digit_next_s = digit_r;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            digit_r <= 4'd0;
        end else begin
            digit_r <= digit_next_s;
        end
    end

endmodule

// File: rtl/keypad_timer.sv
// Keypad receiver for the microwave: synchronises the encoder strobe and
// data, shifts digits into MM:SS in entry mode, and counts down in count mode.
module keypad_timer
    import microwave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clearn,
    input  logic [BCD_W-1:0] D,
    input  logic             loadn,
    input  logic             pgt_1Hz,
    input  logic             enablen,
    input  logic             clr_time,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             zero,
    output logic             done
);

    logic [SYNC_STAGES-1:0] pgt_sync_r;
    logic [SYNC_STAGES-1:0] loadn_sync_r;
    logic [BCD_W-1:0]       d_sync_r [SYNC_STAGES];
    logic                   pgt_prev_r;
    logic                   done_r;

    logic             tick_s;
    logic             loadn_s;
    logic [BCD_W-1:0] d_s;
    logic             shift_s;
    logic             dec_s;
    logic             done_next_s;
    logic             at_one_s;
    logic             so_borrow_s;
    logic             st_borrow_s;
    logic             mo_borrow_s;
    logic             mt_borrow_s;

    assign tick_s   = pgt_sync_r[SYNC_STAGES-1] & ~pgt_prev_r;
    assign loadn_s  = loadn_sync_r[SYNC_STAGES-1];
    assign d_s      = d_sync_r[SYNC_STAGES-1];
    assign zero     = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                      (min_ones == 4'd0) && (min_tens == 4'd0);
    assign at_one_s = (sec_ones == 4'd1) && (sec_tens == 4'd0) &&
                      (min_ones == 4'd0) && (min_tens == 4'd0);
    assign done     = done_r;

    // Synchronisers and edge flop; reset high so a strobe held across reset is not a tick.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            pgt_sync_r   <= {SYNC_STAGES{1'b1}};
            loadn_sync_r <= {SYNC_STAGES{1'b1}};
            pgt_prev_r   <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                d_sync_r[i] <= {BCD_W{1'b1}};
            end
        end else begin
            pgt_sync_r   <= {pgt_sync_r[SYNC_STAGES-2:0], pgt_1Hz};
            loadn_sync_r <= {loadn_sync_r[SYNC_STAGES-2:0], loadn};
            pgt_prev_r   <= pgt_sync_r[SYNC_STAGES-1];
            d_sync_r[0]  <= D;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                d_sync_r[i] <= d_sync_r[i-1];
            end
        end
    end

    // Per-tick action; a borrow out of min_tens means the time is already 00:00.
    always_comb begin
        shift_s     = 1'b0;
        dec_s       = 1'b0;
        done_next_s = 1'b0;
        if (clr_time) begin
            shift_s = 1'b0;
        end else if (tick_s) begin
            case (enablen)
                MODE_ENTRY: begin
                    if (!loadn_s && bcd_valid(d_s)) begin
                        shift_s = 1'b1;
                    end else begin
                        shift_s = 1'b0;
                    end
                end
                MODE_COUNT: begin
                    if (!mt_borrow_s) begin
                        dec_s       = 1'b1;
                        done_next_s = at_one_s;
                    end else begin
                        dec_s = 1'b0;
                    end
                end
                default: begin
                    dec_s = 1'b0;
                end
            endcase
        end else begin
            dec_s = 1'b0;
        end
    end

    // Registered done pulse.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_next_s;
        end
    end

    bcd_digit u_sec_ones (
        .clk(clk), .clearn(clearn), .clr(clr_time), .shift_en(shift_s),
        .shift_in(d_s), .dec_en(dec_s), .borrow_in(1'b1), .wrap_val(BCD_MAX),
        .digit(sec_ones), .borrow_out(so_borrow_s)
    );

    bcd_digit u_sec_tens (
        .clk(clk), .clearn(clearn), .clr(clr_time), .shift_en(shift_s),
        .shift_in(sec_ones), .dec_en(dec_s), .borrow_in(so_borrow_s), .wrap_val(SEC_TENS_MAX),
        .digit(sec_tens), .borrow_out(st_borrow_s)
    );

    bcd_digit u_min_ones (
        .clk(clk), .clearn(clearn), .clr(clr_time), .shift_en(shift_s),
        .shift_in(sec_tens), .dec_en(dec_s), .borrow_in(st_borrow_s), .wrap_val(BCD_MAX),
        .digit(min_ones), .borrow_out(mo_borrow_s)
    );

    bcd_digit u_min_tens (
        .clk(clk), .clearn(clearn), .clr(clr_time), .shift_en(shift_s),
        .shift_in(min_ones), .dec_en(dec_s), .borrow_in(mo_borrow_s), .wrap_val(BCD_MAX),
        .digit(min_tens), .borrow_out(mt_borrow_s)
    );

endmodule

// File: tb/tb_keypad_timer.sv
// Scoreboard bench for keypad_timer: stimulus queues expected MM:SS updates,
// a monitor pops one per observed output change and checks value and latency.
module tb_keypad_timer;

    logic       clk      = 1'b0;
    logic       clearn   = 1'b0;
    logic [3:0] D        = 4'd5;
    logic       loadn    = 1'b0;
    logic       pgt_1Hz  = 1'b1;
    logic       enablen  = 1'b0;
    logic       clr_time = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       zero, done;
    logic [15:0] obs_t;

    typedef struct {
        logic [15:0] t;
        logic        dn;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    bit   mon_en   = 1'b0;

    keypad_timer dut (
        .clk(clk), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .enablen(enablen), .clr_time(clr_time),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .zero(zero), .done(done)
    );

    assign obs_t = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_upd(input logic [15:0] t, input logic dn, input int at);
        exp_t e;
        e.t  = t;
        e.dn = dn;
        e.at = at;
        sb_q.push_back(e);
    endtask

    // One strobe: the update is due on the 3rd rising edge after pgt_1Hz rises.
    task automatic pulse(input logic [3:0] d, input logic ld, input bit upd,
                         input logic [15:0] t, input logic dn);
        @(negedge clk);
        D = d;
        loadn = ld;
        pgt_1Hz = 1'b1;
        if (upd) expect_upd(t, dn, edge_cnt + 3);
        repeat (3) @(negedge clk);
        pgt_1Hz = 1'b0;
        loadn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_time();
        @(negedge clk);
        clr_time = 1'b1;
        expect_upd(16'h0000, 1'b0, edge_cnt + 1);
        @(negedge clk);
        clr_time = 1'b0;
    endtask

    // Monitor: any digit change or a high done is an output event.
    initial begin
        logic [15:0] prev_t;
        exp_t e;
        wait (mon_en);
        prev_t = 16'h0000;
        forever begin
            @(negedge clk);
            if (obs_t !== prev_t || done !== 1'b0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got %h done=%b expected no change", obs_t, done);
                end else begin
                    e = sb_q.pop_front();
                    check("digits", 32'(obs_t), 32'(e.t));
                    check("done", 32'(done), 32'(e.dn));
                    check("zero", 32'(zero), 32'(e.t == 16'h0000));
                    if (e.at >= 0) check("latency_edge", 32'(edge_cnt), 32'(e.at));
                end
                prev_t = obs_t;
            end
        end
    end

    initial begin
        logic [15:0] entry_tbl [5];
        logic [15:0] t;
        entry_tbl[0] = 16'h0001;
        entry_tbl[1] = 16'h0012;
        entry_tbl[2] = 16'h0123;
        entry_tbl[3] = 16'h1234;
        entry_tbl[4] = 16'h2345;

        // 1: strobe and a valid key held high across reset release
        repeat (3) @(negedge clk);
        clearn = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        check("reset_digits", 32'(obs_t), 32'h0000);
        check("reset_zero", 32'(zero), 32'h1);
        check("reset_done", 32'(done), 32'h0);
        pgt_1Hz = 1'b0;
        loadn = 1'b1;
        repeat (3) @(negedge clk);

        // 2: keys 1,3,0 -> 01:30
        pulse(4'd1, 1'b0, 1'b1, 16'h0001, 1'b0);
        pulse(4'd3, 1'b0, 1'b1, 16'h0013, 1'b0);
        pulse(4'd0, 1'b0, 1'b1, 16'h0130, 1'b0);

        // 3: non-BCD key and released key are ignored
        pulse(4'hC, 1'b0, 1'b0, 16'h0000, 1'b0);
        pulse(4'd7, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("hold_after_ignored", 32'(obs_t), 32'h0130);

        // 4: keys 1..5 -> 23:45, then 99 -> 00:99 and one count tick
        clear_time();
        for (int k = 0; k < 5; k++) pulse(4'(k + 1), 1'b0, 1'b1, entry_tbl[k], 1'b0);
        clear_time();
        pulse(4'd9, 1'b0, 1'b1, 16'h0009, 1'b0);
        pulse(4'd9, 1'b0, 1'b1, 16'h0099, 1'b0);
        enablen = 1'b1;
        pulse(4'd0, 1'b1, 1'b1, 16'h0098, 1'b0);

        // 5: count down from 01:00 to 00:00, then one extra tick
        clear_time();
        enablen = 1'b0;
        pulse(4'd1, 1'b0, 1'b1, 16'h0001, 1'b0);
        pulse(4'd0, 1'b0, 1'b1, 16'h0010, 1'b0);
        pulse(4'd0, 1'b0, 1'b1, 16'h0100, 1'b0);
        enablen = 1'b1;
        pulse(4'd0, 1'b1, 1'b1, 16'h0059, 1'b0);
        for (int s = 58; s >= 0; s--) begin
            t = {8'h00, 4'(s / 10), 4'(s % 10)};
            pulse(4'd0, 1'b1, 1'b1, t, (s == 0) ? 1'b1 : 1'b0);
        end
        pulse(4'd0, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("after_extra_tick_digits", 32'(obs_t), 32'h0000);
        check("after_extra_tick_done", 32'(done), 32'h0);

        // 6a: clr_time on the same edge as a count tick at 12:34
        enablen = 1'b0;
        for (int k = 0; k < 4; k++) pulse(4'(k + 1), 1'b0, 1'b1, entry_tbl[k], 1'b0);
        enablen = 1'b1;
        @(negedge clk);
        pgt_1Hz = 1'b1;
        loadn = 1'b1;
        expect_upd(16'h0000, 1'b0, edge_cnt + 3);
        repeat (2) @(negedge clk);
        clr_time = 1'b1;
        @(negedge clk);
        clr_time = 1'b0;
        pgt_1Hz = 1'b0;
        repeat (4) @(negedge clk);

        // 6b: async reset at 00:07 with a tick in flight
        enablen = 1'b0;
        pulse(4'd7, 1'b0, 1'b1, 16'h0007, 1'b0);
        enablen = 1'b1;
        @(negedge clk);
        pgt_1Hz = 1'b1;
        expect_upd(16'h0000, 1'b0, -1);
        @(posedge clk);
        #2 clearn = 1'b0;
        repeat (2) @(negedge clk);
        pgt_1Hz = 1'b0;
        @(negedge clk);
        clearn = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_digits", 32'(obs_t), 32'h0000);
        check("post_reset_done", 32'(done), 32'h0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
